// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the binary-result-to-BCD display converter.
// Leading-zero blanking helper is used when LEAD_ZERO_BLANK_EN is defined.
package disp_pkg;

  localparam int WIDTH = 14;
  localparam int NDIG  = 4;
  localparam int ITER  = 14;
  localparam logic [WIDTH-1:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A digit above the units is blanked when it and every more significant digit are zero,
  // unless the decimal point sits at or above it.
  function automatic logic [NDIG-1:0] lead_blank(input logic [4*NDIG-1:0] bcd,
                                                  input logic dp_en,
                                                  input logic [1:0] dp_pos);
    logic [NDIG-1:0] blk;
    logic            run_zero;
    blk      = 4'b0000;
    run_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      run_zero = run_zero && (bcd[4*i +: 4] == 4'd0);
      blk[i]   = run_zero && (!dp_en || (2'(i) > dp_pos));
    end
    return blk;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the BCD nibble is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/result_to_bcd.sv
// Sequential double-dabble converter feeding a 4-digit display with error/point/blank flags.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module result_to_bcd
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             err_in,
  input  logic             dp_en,
  input  logic [1:0]       dp_pos,
  input  logic             start,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       error,
  output logic [3:0]       dec_point,
  output logic [3:0]       blank,
  output logic             busy,
  output logic             done
);

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [3:0] BLANK_RST = 4'b1110;
`else
  localparam logic [3:0] BLANK_RST = 4'b0000;
`endif
  localparam logic [3:0] LAST_STEP = 4'(ITER - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [4*NDIG-1:0]  bcd_q;
  logic [3:0]         cnt_q;
  logic               err_q;
  logic               ovf_q;
  logic               dpen_q;
  logic [1:0]         dppos_q;
  logic [4*NDIG-1:0]  dig_q;
  logic [3:0]         error_q;
  logic [3:0]         dp_q;
  logic [3:0]         blank_q;
  logic               busy_q;
  logic               done_q;

  logic [4*NDIG-1:0]        bcd_adj;
  logic [4*NDIG+WIDTH-1:0]  shift_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign shift_d = {bcd_adj, bin_q} << 1;

  // Control FSM, shift datapath and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dpen_q  <= 1'b0;
      dppos_q <= 2'd0;
      dig_q   <= '0;
      error_q <= 4'b0000;
      dp_q    <= 4'b0000;
      blank_q <= BLANK_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= value;
            ovf_q   <= (value > MAX_VAL);
            err_q   <= err_in;
            dpen_q  <= dp_en;
            dppos_q <= dp_pos;
            bcd_q   <= '0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CONV: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_CONV;
          end
        end
        ST_DONE: begin
          if (err_q || ovf_q) begin
            dig_q   <= '0;
            error_q <= 4'b1111;
            dp_q    <= 4'b0000;
            blank_q <= 4'b0000;
          end else begin
            dig_q   <= bcd_q;
            error_q <= 4'b0000;
            dp_q    <= dpen_q ? (4'b0001 << dppos_q) : 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
            blank_q <= lead_blank(bcd_q, dpen_q, dppos_q);
`else
            blank_q <= 4'b0000;
`endif
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dig0      = dig_q[3:0];
  assign dig1      = dig_q[7:4];
  assign dig2      = dig_q[11:8];
  assign dig3      = dig_q[15:12];
  assign error     = error_q;
  assign dec_point = dp_q;
  assign blank     = blank_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
